// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, default opcodes and dump FSM states
package uart_pkg;

    localparam logic [7:0]  HDR_BYTE     = 8'hA5;
    localparam logic [7:0]  TRL_BYTE     = 8'h5A;
    localparam logic [23:0] DEF_OP_DUMP  = 24'hF0E0D0;
    localparam logic [23:0] DEF_OP_CLEAR = 24'hC0C1C2;

    typedef enum logic [2:0] {
        DS_IDLE,
        DS_HDR,
        DS_PAYLOAD,
        DS_TRL_MARK,
        DS_TRL_CNT,
        DS_TRL_SUM,
        DS_DRAIN
    } dump_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with glitch-rejecting start check and stop-bit error pulse
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 1736
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_tdata,
    output logic       rx_tvalid,
    output logic       rx_frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t      state_q, state_d;
    logic [1:0]     sync_q;
    logic           rx_prev_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     sh_q;
    logic           rx_s;
    logic           start_edge;
    logic           half_hit;
    logic           bit_hit;

    assign rx_s       = sync_q[1];
    assign start_edge = rx_prev_q & ~rx_s;
    assign half_hit   = (cnt_q == CW'(CLKS_PER_BIT / 2 - 1));
    assign bit_hit    = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign rx_tdata   = sh_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (start_edge) state_d = RX_START;
            // a start bit that is high again at half-bit was a glitch
            RX_START: if (half_hit) state_d = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_hit && bit_idx_q == 3'd7) state_d = RX_STOP;
            RX_STOP:  if (bit_hit) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RX_IDLE;
            sync_q       <= 2'b11;
            rx_prev_q    <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            sh_q         <= '0;
            rx_tvalid    <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[0], rx};
            rx_prev_q    <= rx_s;
            rx_tvalid    <= 1'b0;
            rx_frame_err <= 1'b0;
            if (state_q != state_d || bit_hit) cnt_q <= '0;
            else                               cnt_q <= cnt_q + 1'b1;
            if (state_q == RX_IDLE) bit_idx_q <= '0;
            if (state_q == RX_DATA && bit_hit) begin
                sh_q      <= {rx_s, sh_q[7:1]};
                bit_idx_q <= bit_idx_q + 1'b1;
            end
            if (state_q == RX_STOP && bit_hit) begin
                if (rx_s) rx_tvalid    <= 1'b1;
                else      rx_frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_dump_bridge.sv
// rtl/uart_dump_bridge.sv - UART opcode matcher issuing book dump/clear and framing dump words back on TX
module uart_dump_bridge
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 1736,
    parameter int          WORD_W       = 32,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [23:0] OP_DUMP      = DEF_OP_DUMP,
    parameter logic [23:0] OP_CLEAR     = DEF_OP_CLEAR,
    parameter int          GAP_CLKS     = 4 * 10 * CLKS_PER_BIT
) (
    input  logic              clk_engine,
    input  logic              rst_engine_n,
    input  logic              uart_rx_in,
    output logic              uart_tx_out,
    output logic              cmd_dump,
    output logic              cmd_clear,
    input  logic [WORD_W-1:0] dump_tdata,
    input  logic              dump_tvalid,
    input  logic              dump_tlast,
    input  logic              dump_tuser,
    output logic              dump_tready,
    output logic              busy,
    output logic              rx_frame_err
);

    localparam int NB = WORD_W / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int GW = $clog2(GAP_CLKS + 1);

    logic [7:0] rx_byte;
    logic       rx_valid;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk_engine),
        .rst_n        (rst_engine_n),
        .rx           (uart_rx_in),
        .rx_tdata     (rx_byte),
        .rx_tvalid    (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    // opcode matcher
    logic [23:0]   shift_q;
    logic [1:0]    fill_q;
    logic [GW-1:0] gap_q;
    logic [23:0]   shift_n;
    logic          full_win, clear_hit, dump_match, dump_hit;

    assign shift_n    = {shift_q[15:0], rx_byte};
    assign full_win   = rx_valid && (fill_q >= 2'd2);
    assign clear_hit  = full_win && (shift_n == OP_CLEAR);
    assign dump_match = full_win && (shift_n == OP_DUMP);
    assign dump_hit   = dump_match && !busy;

    always_ff @(posedge clk_engine or negedge rst_engine_n) begin
        if (!rst_engine_n) begin
            shift_q   <= '0;
            fill_q    <= '0;
            gap_q     <= '0;
            cmd_dump  <= 1'b0;
            cmd_clear <= 1'b0;
        end else begin
            cmd_dump  <= dump_hit;
            cmd_clear <= clear_hit;
            if (rx_frame_err) begin
                fill_q <= '0;
                gap_q  <= '0;
            end else if (rx_valid) begin
                gap_q <= '0;
                if (clear_hit || dump_match) begin
                    fill_q  <= '0;
                    shift_q <= '0;
                end else begin
                    fill_q  <= (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
                    shift_q <= shift_n;
                end
            end else if (fill_q != 2'd0) begin
                if (gap_q == GW'(GAP_CLKS)) begin
                    fill_q <= '0;
                    gap_q  <= '0;
                end else begin
                    gap_q <= gap_q + 1'b1;
                end
            end
        end
    end

    // word FIFO; full is taken from registered pointers so a same-cycle pop never frees a slot
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wptr_q, rptr_q;
    logic              fifo_full, fifo_empty, fifo_wr, fifo_pop, beat, tlast_seen_q;
    logic [WORD_W-1:0] fifo_head;

    assign fifo_full   = ((wptr_q - rptr_q) == (AW + 1)'(FIFO_DEPTH));
    assign fifo_empty  = (wptr_q == rptr_q);
    assign fifo_head   = mem[rptr_q[AW-1:0]];
    assign dump_tready = !fifo_full && busy && !tlast_seen_q;
    assign beat        = dump_tvalid && dump_tready;
    assign fifo_wr     = beat && !dump_tuser;

    always_ff @(posedge clk_engine) begin
        if (fifo_wr) mem[wptr_q[AW-1:0]] <= dump_tdata;
    end

    always_ff @(posedge clk_engine or negedge rst_engine_n) begin
        if (!rst_engine_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            tlast_seen_q <= 1'b0;
        end else begin
            if (fifo_wr)  wptr_q <= wptr_q + 1'b1;
            if (fifo_pop) rptr_q <= rptr_q + 1'b1;
            if (dump_hit)                 tlast_seen_q <= 1'b0;
            else if (beat && dump_tlast)  tlast_seen_q <= 1'b1;
        end
    end

    // TX shifter; accepts a new byte in the last cycle of the previous stop bit
    logic [8:0]    tx_sh_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic          tx_active_q, tx_last, tx_ready, tx_load;
    logic [7:0]    tx_byte;

    assign tx_last  = tx_active_q && (tx_cnt_q == CW'(CLKS_PER_BIT - 1)) && (tx_bit_q == 4'd9);
    assign tx_ready = !tx_active_q || tx_last;

    always_ff @(posedge clk_engine or negedge rst_engine_n) begin
        if (!rst_engine_n) begin
            uart_tx_out <= 1'b1;
            tx_sh_q     <= '1;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_active_q <= 1'b0;
        end else if (tx_load) begin
            uart_tx_out <= 1'b0;
            tx_sh_q     <= {1'b1, tx_byte};
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_active_q <= 1'b1;
        end else if (tx_active_q) begin
            if (tx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_active_q <= 1'b0;
                    uart_tx_out <= 1'b1;
                end else begin
                    uart_tx_out <= tx_sh_q[0];
                    tx_sh_q     <= {1'b1, tx_sh_q[8:1]};
                    tx_bit_q    <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

    // dump session FSM
    dump_state_t       ds_q, ds_d;
    logic [WORD_W-1:0] word_sh_q;
    logic [3:0]        bytes_left_q;
    logic [7:0]        cnt_q, sum_q;

    always_comb begin
        ds_d     = ds_q;
        tx_load  = 1'b0;
        tx_byte  = '0;
        fifo_pop = 1'b0;
        case (ds_q)
            DS_IDLE: if (dump_hit) ds_d = DS_HDR;
            DS_HDR: if (tx_ready) begin
                tx_load = 1'b1;
                tx_byte = HDR_BYTE;
                ds_d    = DS_PAYLOAD;
            end
            DS_PAYLOAD: begin
                if (bytes_left_q != 4'd0) begin
                    if (tx_ready) begin
                        tx_load = 1'b1;
                        tx_byte = word_sh_q[WORD_W-1 -: 8];
                    end
                end else if (!fifo_empty) begin
                    if (tx_ready) begin
                        tx_load  = 1'b1;
                        fifo_pop = 1'b1;
                        tx_byte  = fifo_head[WORD_W-1 -: 8];
                    end
                end else if (tlast_seen_q) begin
                    ds_d = DS_TRL_MARK;
                end
            end
            DS_TRL_MARK: if (tx_ready) begin
                tx_load = 1'b1;
                tx_byte = TRL_BYTE;
                ds_d    = DS_TRL_CNT;
            end
            DS_TRL_CNT: if (tx_ready) begin
                tx_load = 1'b1;
                tx_byte = cnt_q;
                ds_d    = DS_TRL_SUM;
            end
            DS_TRL_SUM: if (tx_ready) begin
                tx_load = 1'b1;
                tx_byte = sum_q ^ cnt_q;
                ds_d    = DS_DRAIN;
            end
            DS_DRAIN: if (!tx_active_q) ds_d = DS_IDLE;
            default: ds_d = DS_IDLE;
        endcase
    end

    always_ff @(posedge clk_engine or negedge rst_engine_n) begin
        if (!rst_engine_n) begin
            ds_q         <= DS_IDLE;
            busy         <= 1'b0;
            word_sh_q    <= '0;
            bytes_left_q <= '0;
            cnt_q        <= '0;
            sum_q        <= '0;
        end else begin
            ds_q <= ds_d;
            if (dump_hit) begin
                busy         <= 1'b1;
                cnt_q        <= '0;
                sum_q        <= '0;
                bytes_left_q <= '0;
            end else if (ds_q == DS_DRAIN && !tx_active_q) begin
                busy <= 1'b0;
            end
            if (tx_load && ds_q == DS_PAYLOAD) begin
                sum_q <= sum_q ^ tx_byte;
                if (fifo_pop) begin
                    word_sh_q    <= fifo_head << 8;
                    bytes_left_q <= 4'(NB - 1);
                    cnt_q        <= cnt_q + 8'd1;
                end else begin
                    word_sh_q    <= word_sh_q << 8;
                    bytes_left_q <= bytes_left_q - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_dump_bridge.sv
// tb/tb_uart_dump_bridge.sv - self-checking bench for uart_dump_bridge
module tb_uart_dump_bridge;

    localparam int CPB = 16;
    localparam int GAP = 4 * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        uart_tx_out;
    logic        cmd_dump, cmd_clear;
    logic [31:0] dump_tdata = '0;
    logic        dump_tvalid = 1'b0;
    logic        dump_tlast = 1'b0;
    logic        dump_tuser = 1'b0;
    logic        dump_tready, busy, rx_frame_err;

    uart_dump_bridge #(
        .CLKS_PER_BIT (CPB),
        .WORD_W       (32),
        .FIFO_DEPTH   (16),
        .GAP_CLKS     (GAP)
    ) dut (
        .clk_engine   (clk),
        .rst_engine_n (rst_n),
        .uart_rx_in   (uart_rx),
        .uart_tx_out  (uart_tx_out),
        .cmd_dump     (cmd_dump),
        .cmd_clear    (cmd_clear),
        .dump_tdata   (dump_tdata),
        .dump_tvalid  (dump_tvalid),
        .dump_tlast   (dump_tlast),
        .dump_tuser   (dump_tuser),
        .dump_tready  (dump_tready),
        .busy         (busy),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int n_dump = 0;
    int n_clear = 0;
    int n_ferr = 0;
    bit hdr_due = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] mcnt;
    logic [7:0] msum;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (hdr_due) check("hdr_start_low", {31'd0, uart_tx_out}, 32'd0);
        hdr_due = cmd_dump;
        if (cmd_dump) begin
            n_dump++;
            check("busy_with_cmd_dump", {31'd0, busy}, 32'd1);
        end
        if (cmd_clear) n_clear++;
        if (rx_frame_err) n_ferr++;
    end

    task automatic mon_wait(input int n, inout bit ab);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!rst_n) ab = 1'b1;
        end
    endtask

    // TX monitor: decodes each byte and compares it against the scoreboard head
    initial begin
        logic [7:0] b;
        bit ab;
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx_out == 1'b0) begin
                ab = 1'b0;
                mon_wait(CPB / 2, ab);
                for (int i = 0; i < 8; i++) begin
                    mon_wait(CPB, ab);
                    b[i] = uart_tx_out;
                end
                mon_wait(CPB, ab);
                if (!ab && uart_tx_out !== 1'b1) check("tx_stop_bit", {31'd0, uart_tx_out}, 32'd1);
                if (!ab) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL tx_unexpected: got %0h expected no byte", b);
                    end else begin
                        check("tx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_ok;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        if (!stop_ok) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_op(input logic [23:0] op);
        send_byte(op[23:16], 1'b1);
        send_byte(op[15:8], 1'b1);
        send_byte(op[7:0], 1'b1);
    endtask

    task automatic push_word(input logic [31:0] d, input bit last, input bit user,
                             output bit ok, output bit stalled);
        dump_tdata  = d;
        dump_tlast  = last;
        dump_tuser  = user;
        dump_tvalid = 1'b1;
        ok = 1'b0;
        stalled = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (dump_tready) begin
                ok = 1'b1;
                break;
            end
            stalled = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        dump_tvalid = 1'b0;
        dump_tlast  = 1'b0;
        dump_tuser  = 1'b0;
        if (!ok) check("beat_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic exp_start();
        exp_q.push_back(8'hA5);
        mcnt = 8'd0;
        msum = 8'd0;
    endtask

    task automatic exp_word(input logic [31:0] w);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = w[31 - 8 * k -: 8];
            exp_q.push_back(b);
            msum = msum ^ b;
        end
        mcnt = mcnt + 8'd1;
    endtask

    task automatic exp_trailer();
        exp_q.push_back(8'h5A);
        exp_q.push_back(mcnt);
        exp_q.push_back(msum ^ mcnt);
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && busy; i++) @(negedge clk);
        check("busy_fall", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);
        check("tx_queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_two_word();
        bit ok, st;
        int d0;
        d0 = n_dump;
        exp_start();
        send_op(24'hF0E0D0);
        check("two_word_cmd_dump", n_dump - d0, 32'd1);
        push_word(32'h0069000A, 1'b0, 1'b0, ok, st);
        if (ok) exp_word(32'h0069000A);
        push_word(32'h00640014, 1'b1, 1'b0, ok, st);
        if (ok) exp_word(32'h00640014);
        exp_trailer();
        wait_idle(5000);
        check("two_word_tready_after", {31'd0, dump_tready}, 32'd0);
    endtask

    typedef struct {
        logic [23:0] op;
        bit          bad_stop0;
        int          gap01;
        int          exp_dump;
        int          exp_clear;
        int          exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit ok, st;
        int d0, c0, f0, first_stall;

        vecs[0] = '{24'hF0E0D0, 1'b0, 0,   1, 0, 0};
        vecs[1] = '{24'hC0C1C2, 1'b0, 0,   0, 1, 0};
        vecs[2] = '{24'hF0E0D0, 1'b0, 700, 0, 0, 0};
        vecs[3] = '{24'hF0E0D0, 1'b0, 400, 1, 0, 0};
        vecs[4] = '{24'hF0E0D0, 1'b1, 0,   0, 0, 1};
        vecs[5] = '{24'hF0E0D1, 1'b0, 0,   0, 0, 0};
        vecs[6] = '{24'hD0E0F0, 1'b0, 0,   0, 0, 0};

        repeat (3) @(negedge clk);
        check("rst_tx_high", {31'd0, uart_tx_out}, 32'd1);
        check("rst_cmd_dump", {31'd0, cmd_dump}, 32'd0);
        check("rst_cmd_clear", {31'd0, cmd_clear}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_err", {31'd0, rx_frame_err}, 32'd0);
        check("rst_tready", {31'd0, dump_tready}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            d0 = n_dump; c0 = n_clear; f0 = n_ferr;
            if (vecs[v].exp_dump != 0) exp_start();
            send_byte(vecs[v].op[23:16], !vecs[v].bad_stop0);
            repeat (vecs[v].gap01) @(negedge clk);
            send_byte(vecs[v].op[15:8], 1'b1);
            send_byte(vecs[v].op[7:0], 1'b1);
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d_dump", v), n_dump - d0, vecs[v].exp_dump);
            check($sformatf("vec%0d_clear", v), n_clear - c0, vecs[v].exp_clear);
            check($sformatf("vec%0d_ferr", v), n_ferr - f0, vecs[v].exp_ferr);
            if (vecs[v].exp_dump != 0) begin
                push_word(32'd0, 1'b1, 1'b1, ok, st);
                exp_trailer();
                wait_idle(5000);
            end
            repeat (GAP + 200) @(negedge clk);
        end

        run_two_word();
        repeat (100) @(negedge clk);

        // 20-word dump with FIFO back-pressure, plus clear and a redundant dump mid-session
        d0 = n_dump; c0 = n_clear;
        first_stall = -1;
        exp_start();
        send_op(24'hF0E0D0);
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    push_word(32'h11000000 + i * 32'h00010203, i == 19, 1'b0, ok, st);
                    if (st && first_stall < 0) first_stall = i;
                    if (ok) exp_word(32'h11000000 + i * 32'h00010203);
                end
                exp_trailer();
            end
            begin
                repeat (3000) @(negedge clk);
                send_op(24'hC0C1C2);
                repeat (200) @(negedge clk);
                send_op(24'hF0E0D0);
            end
        join
        check("big_first_stall_idx", first_stall, 32'd16);
        check("big_count_byte", {24'd0, mcnt}, 32'h14);
        wait_idle(20000);
        check("big_clear_pulses", n_clear - c0, 32'd1);
        check("big_dump_pulses", n_dump - d0, 32'd1);
        repeat (GAP + 200) @(negedge clk);

        // reset in the middle of the payload
        exp_start();
        send_op(24'hF0E0D0);
        for (int i = 0; i < 8; i++) begin
            push_word(32'hA0B0C0D0 + i, 1'b0, 1'b0, ok, st);
            if (ok) exp_word(32'hA0B0C0D0 + i);
        end
        repeat (400) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_high", {31'd0, uart_tx_out}, 32'd1);
        check("midrst_busy_low", {31'd0, busy}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_tready", {31'd0, dump_tready}, 32'd0);
        check("postrst_busy", {31'd0, busy}, 32'd0);
        repeat (100) @(negedge clk);
        run_two_word();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
